instr_sequencer: RTL and testbench
==================================

Name: instr_sequencer

Overview:
Multi-cycle instruction sequencer for the simple microprocessor datapath.
- Buffers incoming 16-bit instructions in a small FIFO.
- Walks each instruction through FETCH, DECODE, EXEC and WB.
- Feeds the opcode to the registered control decoder, drives register-file addresses, and issues one-cycle execute and write-back strobes.
- Sits between the instruction source (testbench or host) and the Control/ALU/register-file datapath.

Parameters:
FIFO_DEPTH, 4, instruction buffer entries; power of two, at least 2
CNT_W, 16, width of the retired-instruction counter

Ports:
clk  in  1  system clock, all state on rising edge
rst  in  1  asynchronous, active-high reset
in_instr  in  16  instruction: [15:12] opcode, [11:8] rd, [7:4] rs1, [3:0] rs2/imm
in_valid  in  1  in_instr valid
in_ready  out  1  FIFO can accept
halt  in  1  hold in IDLE, do not start new instructions
flush  in  1  discard all buffered instructions; honoured only in IDLE
opcode_out  out  4  opcode to control decoder
rd_addr  out  4  destination register
rs1_addr  out  4  source register 1
rs2_imm  out  4  source register 2 or immediate
exec_en  out  1  one-cycle ALU execute strobe
read_strobe  out  1  one-cycle strobe for READ (opcode 4'h2)
wb_en  out  1  one-cycle register write-back strobe
done  out  1  one-cycle retire pulse
busy  out  1  high in any state other than IDLE
fifo_count  out  log2(FIFO_DEPTH)+1  buffered entries
retired_count  out  CNT_W  retired instructions, wraps at 2^CNT_W

Behaviour:
- Reset: asynchronous, active-high; this is fixed. Reset drives every output to 0 except in_ready, which goes to 1. FIFO is emptied, state goes to IDLE, and any in-flight instruction is dropped without wb_en or done.
- All outputs are registered.
- Push rule: push occurs when in_valid && in_ready.
  - in_ready = !full && !(flush && state==IDLE).
  - No push when full, even if a pop happens the same cycle.
- Pop occurs only in FETCH. The FIFO is never popped while empty.
- flush in IDLE clears the FIFO (count becomes 0) and drops any same-cycle push. flush in other states is ignored.
- FSM states: IDLE, FETCH, DECODE, EXEC, WB.
  - IDLE: if !halt && count!=0, go to FETCH. Otherwise stay.
  - FETCH: pop the head and latch opcode_out, rd_addr, rs1_addr, rs2_imm. Go to DECODE. These fields hold until the next FETCH.
  - DECODE: single wait cycle that absorbs the decoder's one-cycle registered latency. Go to EXEC.
  - EXEC: exec_en=1.
    - Opcode 4'h0 (NOP) or 4'h2 (READ): done=1, increment retired_count, go to IDLE. read_strobe=1 for READ only.
    - All other opcodes go to WB.
  - WB: wb_en=1, done=1, increment retired_count.
    - If !halt && count!=0 after the pop, go to FETCH; otherwise go to IDLE.
- Timing, handshake in cycle N with the FIFO empty:
  - IDLE at N+1, FETCH at N+2, DECODE at N+3, EXEC at N+4 (exec_en).
  - WB at N+5 (wb_en, done) for write-class opcodes.
- Back-to-back write-class throughput: 4 cycles per instruction (WB goes straight to FETCH).
- halt never aborts an instruction in progress. It is sampled only in IDLE and at WB exit.
- retired_count wraps from all-ones to 0 with no flag.
- exec_en, read_strobe, wb_en and done are each high for exactly one cycle per instruction. Never two instructions' strobes in the same cycle.

Optional Feature:
SEQ_STEP_EN
- Defined: adds input step (1 bit). IDLE leaves for FETCH only when step==1 && !halt && count!=0. WB always returns to IDLE. Exactly one instruction runs per step pulse; a step held high for several cycles still starts only one instruction per IDLE visit.
- Undefined: no step port; behaviour as above.

Test Plan:
- Reset mid-EXEC of ADD 16'hA123, then release → wb_en never pulses, retired_count=0, fifo_count=0, in_ready=1, state IDLE.
- Push 16'hA312 into empty FIFO at cycle N → opcode_out=4'hA, rd_addr=3, rs1_addr=1, rs2_imm=2 from N+3; exec_en at N+4; wb_en and done at N+5; retired_count=1.
- Push NOP 16'h0000, then READ 16'h2050 → each retires from EXEC with no wb_en; read_strobe pulses once, for READ only; retired_count=2.
- halt=1, push 5 instructions with FIFO_DEPTH=4 → 4 accepted, in_ready=0 on the 5th, fifo_count=4, busy=0. Release halt → 4 retirements, 4 cycles apart.
- halt=1, fill 3 entries, then assert flush and in_valid together in IDLE → fifo_count=0, push dropped; after halt=0, no exec_en occurs.
- SEQ_STEP_EN defined: 2 instructions queued, step held high 20 cycles → one done per IDLE visit, both retire, retired_count=2; with step=0 nothing executes.

Source files
------------

// File: rtl/instr_sequencer.sv
// Multi-cycle instruction sequencer: FIFO-buffered 16-bit instructions walked through FETCH/DECODE/EXEC/WB.
// Optional single-step mode when SEQ_STEP_EN is defined (adds the step input).
module instr_sequencer #(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned CNT_W      = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [15:0]                   in_instr,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic                          halt,
    input  logic                          flush,
`ifdef SEQ_STEP_EN
    input  logic                          step,
`endif
    output logic [3:0]                    opcode_out,
    output logic [3:0]                    rd_addr,
    output logic [3:0]                    rs1_addr,
    output logic [3:0]                    rs2_imm,
    output logic                          exec_en,
    output logic                          read_strobe,
    output logic                          wb_en,
    output logic                          done,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic [CNT_W-1:0]              retired_count
);

    localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_FW = PTR_W + 1;

    typedef enum logic [2:0] {IDLE, FETCH, DECODE, EXEC, WB} state_t;

    state_t              state, state_nx;
    logic [15:0]         mem [FIFO_DEPTH];
    logic [PTR_W-1:0]    wr_ptr, rd_ptr;
    logic [CNT_FW-1:0]   count_nx;
    logic                push, pop, do_flush, go_on, start, is_short;
    logic                exec_nx, read_nx, wb_nx, done_nx;

    // Next-state, FIFO control and strobe decode
    always_comb begin
        state_nx = state;
        exec_nx  = 1'b0;
        read_nx  = 1'b0;
        wb_nx    = 1'b0;
        done_nx  = 1'b0;

        do_flush = flush && (state == IDLE);
        push     = in_valid && in_ready && !do_flush;
        pop      = (state == FETCH) && (fifo_count != '0);
        go_on    = !halt && (fifo_count != '0);
`ifdef SEQ_STEP_EN
        start    = go_on && step;
`else
        start    = go_on;
`endif
        // NOP and READ retire straight out of EXEC
        is_short = (opcode_out == 4'h0) || (opcode_out == 4'h2);

        case (state)
            IDLE:   if (start) state_nx = FETCH;
            FETCH:  state_nx = DECODE;
            DECODE: begin
                state_nx = EXEC;
                exec_nx  = 1'b1;
                if (is_short) begin
                    done_nx = 1'b1;
                    read_nx = (opcode_out == 4'h2);
                end
            end
            EXEC: begin
                if (is_short) begin
                    state_nx = IDLE;
                end else begin
                    state_nx = WB;
                    wb_nx    = 1'b1;
                    done_nx  = 1'b1;
                end
            end
            WB: begin
`ifdef SEQ_STEP_EN
                state_nx = IDLE;
`else
                state_nx = go_on ? FETCH : IDLE;
`endif
            end
            default: state_nx = IDLE;
        endcase

        if (do_flush)
            count_nx = '0;
        else
            count_nx = fifo_count + CNT_FW'(push) - CNT_FW'(pop);
    end

    // Instruction storage (no reset needed; occupancy tracked by pointers)
    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= in_instr;
    end

    // State, pointers and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            fifo_count    <= '0;
            in_ready      <= 1'b1;
            opcode_out    <= '0;
            rd_addr       <= '0;
            rs1_addr      <= '0;
            rs2_imm       <= '0;
            exec_en       <= 1'b0;
            read_strobe   <= 1'b0;
            wb_en         <= 1'b0;
            done          <= 1'b0;
            busy          <= 1'b0;
            retired_count <= '0;
        end else begin
            state <= state_nx;
            if (do_flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (push) wr_ptr <= wr_ptr + PTR_W'(1);
                if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            end
            fifo_count <= count_nx;
            in_ready   <= (count_nx != CNT_FW'(FIFO_DEPTH));
            if (pop) begin
                opcode_out <= mem[rd_ptr][15:12];
                rd_addr    <= mem[rd_ptr][11:8];
                rs1_addr   <= mem[rd_ptr][7:4];
                rs2_imm    <= mem[rd_ptr][3:0];
            end
            exec_en     <= exec_nx;
            read_strobe <= read_nx;
            wb_en       <= wb_nx;
            done        <= done_nx;
            busy        <= (state_nx != IDLE);
            if (done_nx)
                retired_count <= retired_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed self-checking bench for instr_sequencer; step scenario runs only when SEQ_STEP_EN is defined.
module tb_instr_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] in_instr;
    logic        in_valid;
    logic        in_ready;
    logic        halt;
    logic        flush;
`ifdef SEQ_STEP_EN
    logic        step;
`endif
    logic [3:0]  opcode_out, rd_addr, rs1_addr, rs2_imm;
    logic        exec_en, read_strobe, wb_en, done, busy;
    logic [2:0]  fifo_count;
    logic [15:0] retired_count;

    int n_cmp = 0;
    int n_err = 0;
    int n_exec = 0, n_read = 0, n_wb = 0, n_done = 0;

    instr_sequencer #(.FIFO_DEPTH(4), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .in_instr(in_instr), .in_valid(in_valid), .in_ready(in_ready),
        .halt(halt), .flush(flush),
`ifdef SEQ_STEP_EN
        .step(step),
`endif
        .opcode_out(opcode_out), .rd_addr(rd_addr), .rs1_addr(rs1_addr), .rs2_imm(rs2_imm),
        .exec_en(exec_en), .read_strobe(read_strobe), .wb_en(wb_en), .done(done), .busy(busy),
        .fifo_count(fifo_count), .retired_count(retired_count)
    );

    always #5 clk = ~clk;

    // Strobe pulse counters, sampled mid-cycle
    always @(negedge clk) begin
        if (exec_en)     n_exec++;
        if (read_strobe) n_read++;
        if (wb_en)       n_wb++;
        if (done)        n_done++;
    end

    // Present one instruction for one cycle; call #1 after a rising edge
    task automatic push_one(input logic [15:0] w);
        in_valid = 1'b1;
        in_instr = w;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic tick(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic test_reset();
        int wb0;
        rst = 1'b1; in_valid = 1'b0; in_instr = '0; halt = 1'b0; flush = 1'b0;
`ifdef SEQ_STEP_EN
        step = 1'b1;
`endif
        tick(2);
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
        n_cmp++; if ({exec_en, wb_en, done, busy, read_strobe} !== 5'b0) begin n_err++;
            $display("FAIL reset_strobes got=%b exp=00000", {exec_en, wb_en, done, busy, read_strobe}); end
        n_cmp++; if (retired_count !== 16'd0 || fifo_count !== 3'd0) begin n_err++;
            $display("FAIL reset_counts got=%0d/%0d exp=0/0", retired_count, fifo_count); end
        rst = 1'b0;
        tick(1);
        wb0 = n_wb;
        push_one(16'hA123);
        tick(3);
        n_cmp++; if (exec_en !== 1'b1) begin n_err++; $display("FAIL rst_mid_exec_en got=%b exp=1", exec_en); end
        rst = 1'b1; #1;
        n_cmp++; if ({exec_en, busy, in_ready} !== 3'b001) begin n_err++;
            $display("FAIL async_reset got=%b exp=001", {exec_en, busy, in_ready}); end
        @(posedge clk); #1; rst = 1'b0;
        tick(6);
        n_cmp++; if (n_wb !== wb0) begin n_err++; $display("FAIL rst_no_wb got=%0d exp=%0d", n_wb, wb0); end
        n_cmp++; if (retired_count !== 16'd0 || fifo_count !== 3'd0 || in_ready !== 1'b1 || busy !== 1'b0) begin n_err++;
            $display("FAIL rst_after got=ret%0d cnt%0d rdy%b busy%b exp=ret0 cnt0 rdy1 busy0",
                     retired_count, fifo_count, in_ready, busy); end
    endtask

    task automatic test_write();
        push_one(16'hA312);                          // now cycle N+1
        n_cmp++; if (fifo_count !== 3'd1 || busy !== 1'b0) begin n_err++;
            $display("FAIL wr_n1 got=cnt%0d busy%b exp=cnt1 busy0", fifo_count, busy); end
        tick(2);                                     // N+3
        n_cmp++; if ({opcode_out, rd_addr, rs1_addr, rs2_imm} !== 16'hA312) begin n_err++;
            $display("FAIL wr_fields got=%h exp=a312", {opcode_out, rd_addr, rs1_addr, rs2_imm}); end
        n_cmp++; if (exec_en !== 1'b0 || fifo_count !== 3'd0) begin n_err++;
            $display("FAIL wr_n3 got=ex%b cnt%0d exp=ex0 cnt0", exec_en, fifo_count); end
        tick(1);                                     // N+4
        n_cmp++; if ({exec_en, wb_en, done} !== 3'b100) begin n_err++;
            $display("FAIL wr_n4 got=%b exp=100", {exec_en, wb_en, done}); end
        tick(1);                                     // N+5
        n_cmp++; if ({exec_en, wb_en, done} !== 3'b011 || retired_count !== 16'd1) begin n_err++;
            $display("FAIL wr_n5 got=%b ret=%0d exp=011 ret=1", {exec_en, wb_en, done}, retired_count); end
        tick(1);
        n_cmp++; if ({wb_en, done, busy} !== 3'b000) begin n_err++;
            $display("FAIL wr_n6 got=%b exp=000", {wb_en, done, busy}); end
    endtask

    task automatic test_nop_read();
        int wb0, rd0, dn0, ex0;
        wb0 = n_wb; rd0 = n_read; dn0 = n_done; ex0 = n_exec;
        push_one(16'h0000);
        tick(8);
        n_cmp++; if (n_read !== rd0) begin n_err++; $display("FAIL nop_no_read got=%0d exp=%0d", n_read, rd0); end
        push_one(16'h2050);
        tick(3);                                     // EXEC of READ
        n_cmp++; if ({exec_en, read_strobe, done, wb_en} !== 4'b1110) begin n_err++;
            $display("FAIL read_exec got=%b exp=1110", {exec_en, read_strobe, done, wb_en}); end
        tick(6);
        n_cmp++; if (n_wb !== wb0 || n_read !== rd0 + 1) begin n_err++;
            $display("FAIL nop_read_strobes got=wb%0d rd%0d exp=wb%0d rd%0d", n_wb, n_read, wb0, rd0 + 1); end
        n_cmp++; if (n_done !== dn0 + 2 || n_exec !== ex0 + 2 || retired_count !== 16'd3) begin n_err++;
            $display("FAIL nop_read_retire got=dn%0d ex%0d ret%0d exp=dn%0d ex%0d ret3",
                     n_done, n_exec, retired_count, dn0 + 2, ex0 + 2); end
    endtask

    task automatic test_back_to_back();
        int acc, nd, ex0;
        int t [4];
        halt = 1'b1; acc = 0; ex0 = n_exec;
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            in_instr = 16'h1000 | 16'(i << 8);
            if (in_ready) acc++;
            if (i == 4) begin
                n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL full_ready got=%b exp=0", in_ready); end
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        tick(3);
        n_cmp++; if (acc !== 4 || fifo_count !== 3'd4 || busy !== 1'b0 || n_exec !== ex0) begin n_err++;
            $display("FAIL full_state got=acc%0d cnt%0d busy%b ex%0d exp=acc4 cnt4 busy0 ex%0d",
                     acc, fifo_count, busy, n_exec, ex0); end
        halt = 1'b0; nd = 0;
        for (int c = 1; c <= 30; c++) begin
            @(posedge clk); #1;
            if (done) begin
                if (nd < 4) t[nd] = c;
                nd++;
            end
        end
        n_cmp++; if (nd !== 4) begin n_err++; $display("FAIL b2b_count got=%0d exp=4", nd); end
        else begin
            n_cmp++; if (t[0] !== 4 || t[1] !== 8 || t[2] !== 12 || t[3] !== 16) begin n_err++;
                $display("FAIL b2b_spacing got=%0d,%0d,%0d,%0d exp=4,8,12,16", t[0], t[1], t[2], t[3]); end
        end
        n_cmp++; if (retired_count !== 16'd7 || fifo_count !== 3'd0 || in_ready !== 1'b1) begin n_err++;
            $display("FAIL b2b_end got=ret%0d cnt%0d rdy%b exp=ret7 cnt0 rdy1", retired_count, fifo_count, in_ready); end
    endtask

    task automatic test_flush();
        int ex0;
        halt = 1'b1; ex0 = n_exec;
        push_one(16'h3111);
        push_one(16'h3222);
        push_one(16'h3333);
        n_cmp++; if (fifo_count !== 3'd3) begin n_err++; $display("FAIL flush_pre got=%0d exp=3", fifo_count); end
        in_valid = 1'b1; flush = 1'b1; in_instr = 16'h4444;
        @(posedge clk); #1;
        in_valid = 1'b0; flush = 1'b0;
        n_cmp++; if (fifo_count !== 3'd0 || in_ready !== 1'b1) begin n_err++;
            $display("FAIL flush_clear got=cnt%0d rdy%b exp=cnt0 rdy1", fifo_count, in_ready); end
        halt = 1'b0;
        tick(10);
        n_cmp++; if (n_exec !== ex0 || busy !== 1'b0 || retired_count !== 16'd7) begin n_err++;
            $display("FAIL flush_idle got=ex%0d busy%b ret%0d exp=ex%0d busy0 ret7", n_exec, busy, retired_count, ex0); end
    endtask

`ifdef SEQ_STEP_EN
    task automatic test_step();
        int ex0, dn0;
        step = 1'b0; ex0 = n_exec; dn0 = n_done;
        push_one(16'h5123);
        push_one(16'h6456);
        tick(10);
        n_cmp++; if (n_exec !== ex0 || fifo_count !== 3'd2) begin n_err++;
            $display("FAIL step_hold got=ex%0d cnt%0d exp=ex%0d cnt2", n_exec, fifo_count, ex0); end
        step = 1'b1;
        tick(20);
        step = 1'b0;
        n_cmp++; if (n_done !== dn0 + 2 || retired_count !== 16'd9) begin n_err++;
            $display("FAIL step_run got=dn%0d ret%0d exp=dn%0d ret9", n_done, retired_count, dn0 + 2); end
    endtask
`endif

    initial begin
        test_reset();
        test_write();
        test_nop_read();
        test_back_to_back();
        test_flush();
`ifdef SEQ_STEP_EN
        test_step();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
